tick_interval_meter: RTL and testbench
======================================

Name: tick_interval_meter

Overview:
- Measures the number of clk cycles between successive rising edges of a tick or pulse input, such as a delay_tick from the programmable tick generator, a debounced button level or an external strobe.
- It is the reader for our tick-generation path: instead of producing a tick after a programmed delay, it recovers the delay from observed ticks.
- The result feeds the seven-segment display path or a register interface.
- It supports single-shot and continuous measurement, with overflow detection at a programmable ceiling.

Parameters:
- M, 50_000_000: largest measurable interval in clk cycles (500 ms at 100 MHz); counts reaching M without an edge are reported as overflow.
- N, $clog2(M+1): result and counter width; M must be representable.

Ports:
- clk, input, 1: system clock (100 MHz nominal).
- reset, input, 1: asynchronous, active-low reset; one clock domain only.
- tick_in, input, 1: signal to measure; synchronous to clk; only rising edges count.
- start, input, 1: single-cycle request to begin measuring; honoured only in IDLE.
- continuous, input, 1: sampled with start; 1 selects back-to-back measurements.
- stop, input, 1: aborts any measurement and returns to IDLE.
- interval, output, N: last measured interval in clk cycles; held until the next result.
- valid, output, 1: one-cycle pulse when interval/overflow update.
- overflow, output, 1: 1 when the last result timed out; updates with valid.
- busy, output, 1: 1 whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, interval=0, valid=0, overflow=0, cont_r=0, tick_prev=1.
  - tick_prev resets to 1 so that tick_in already high at reset release is not seen as an edge.
- Edge detect: tick_prev <= tick_in every cycle; rise = tick_in & ~tick_prev.
  - A level held high yields exactly one rise.
  - rise is acted on only in ARM and MEASURE.
- IDLE: valid=0.
  - start=1 and stop=0: cont_r <= continuous, go to ARM.
  - start and stop together: remain in IDLE.
  - A rise in the same cycle as start is ignored.
- ARM: waits for the first rise.
  - On rise: cnt <= 1, go to MEASURE.
  - stop: go to IDLE.
- MEASURE: cnt equals the cycles elapsed since the first rise. Priority, highest first:
  1. stop: go to IDLE, no valid, interval/overflow unchanged.
  2. rise: interval <= cnt, overflow <= 0, valid <= 1 next cycle. Then cont_r=1: cnt <= 1, stay in MEASURE (this edge opens the next window). cont_r=0: go to IDLE.
  3. cnt == M: interval <= M, overflow <= 1, valid <= 1. Then cont_r=1: go to ARM. cont_r=0: go to IDLE.
  4. Otherwise: cnt <= cnt + 1.
- Boundary cases:
  - A rise exactly when cnt == M is a valid measurement: interval=M, overflow=0.
  - cnt never exceeds M, so there is no wraparound.
- Latency:
  - valid and the interval/overflow update are registered; they appear the cycle after the terminating rise or timeout is sampled.
  - In single-shot mode, busy falls in that same cycle.
- Example: rises at cycles t0 and t1 give interval = t1 - t0. Back-to-back rises (tick_in toggling each cycle) give interval=2.
- Mode changes: continuous and cont_r change only via start in IDLE; changes to continuous at other times have no effect.
- Reset mid-operation aborts immediately: outputs return to their reset values, and no valid is issued.

Test Plan:
- Single-shot: start with continuous=0; tick_in pulses every 5 cycles (generator delay 5) -> one valid with interval=5, overflow=0; busy falls with valid; later pulses produce nothing.
- Continuous: start with continuous=1; rises spaced 3, 7, 4 cycles -> three valid pulses with interval 3, 7, 4 in order; busy stays 1; stop -> IDLE, interval holds 4.
- Timeout: M=20, single-shot, one rise then none -> valid 20 cycles after the first rise with interval=20, overflow=1. A rise exactly 20 cycles apart -> interval=20, overflow=0. In continuous mode, after a timeout, busy=1 and the next two rises 6 apart -> interval=6.
- Level input: tick_in held high for 10 cycles, low 2, high again -> interval=12, a single valid.
- Abort and collisions: stop mid-MEASURE -> no valid, busy=0, previous interval/overflow retained. start and stop together in IDLE -> busy stays 0. A rise coincident with start -> ignored, and the measurement begins at the next rise.
- Reset: assert reset low mid-MEASURE -> interval=0, valid=0, overflow=0, busy=0 without waiting for a clk edge. Release reset with tick_in high, then start -> no edge counted until tick_in falls and rises again.

Source files
------------

// File: rtl/tick_interval_meter_if.sv
// Control and result bundle of the tick interval meter.
// The master drives the tick and the commands; the slave (the meter) returns results.
interface tick_interval_meter_if #(
  parameter int N = 26
);
  logic         tick_in;
  logic         start;
  logic         continuous;
  logic         stop;
  logic [N-1:0] interval;
  logic         valid;
  logic         overflow;
  logic         busy;

  modport master (
    output tick_in, start, continuous, stop,
    input  interval, valid, overflow, busy
  );

  modport slave (
    input  tick_in, start, continuous, stop,
    output interval, valid, overflow, busy
  );
endinterface

// File: rtl/tick_interval_meter.sv
// Measures clk cycles between successive rising edges of tick_in.
// Supports single-shot or continuous measurement, with a timeout at M cycles.
module tick_interval_meter #(
  parameter int M = 50_000_000,
  parameter int N = $clog2(M + 1)
) (
  input logic                  clk,
  input logic                  reset,
  tick_interval_meter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [N-1:0] MAX = N'(M);
  localparam logic [N-1:0] ONE = N'(1);

  state_t       state, state_nx;
  logic [N-1:0] cnt, cnt_nx;
  logic [N-1:0] interval, interval_nx;
  logic         valid, valid_nx;
  logic         overflow, overflow_nx;
  logic         cont_r, cont_nx;
  logic         tick_prev;
  logic         rise;

  // tick_prev resets high so a level already high at reset release is not an edge
  assign rise = bus.tick_in & ~tick_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      interval  <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      cont_r    <= 1'b0;
      tick_prev <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      interval  <= interval_nx;
      valid     <= valid_nx;
      overflow  <= overflow_nx;
      cont_r    <= cont_nx;
      tick_prev <= bus.tick_in;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    interval_nx = interval;
    valid_nx    = 1'b0;
    overflow_nx = overflow;
    cont_nx     = cont_r;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          cont_nx  = bus.continuous;
          state_nx = ARM;
        end
      end
      ARM: begin
        if (bus.stop) begin
          state_nx = IDLE;
        end else if (rise) begin
          cnt_nx   = ONE;
          state_nx = MEASURE;
        end
      end
      MEASURE: begin
        // A rise at cnt == MAX still counts as a valid measurement
        if (bus.stop) begin
          state_nx = IDLE;
        end else if (rise) begin
          interval_nx = cnt;
          overflow_nx = 1'b0;
          valid_nx    = 1'b1;
          if (cont_r) cnt_nx = ONE;
          else        state_nx = IDLE;
        end else if (cnt == MAX) begin
          interval_nx = MAX;
          overflow_nx = 1'b1;
          valid_nx    = 1'b1;
          state_nx    = cont_r ? ARM : IDLE;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.interval = interval;
  assign bus.valid    = valid;
  assign bus.overflow = overflow;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_tick_interval_meter.sv
// Directed bench for tick_interval_meter with a 20-cycle ceiling.
module tb_tick_interval_meter;

  localparam int M = 20;
  localparam int N = $clog2(M + 1);

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  tick_interval_meter_if #(.N(N)) bus ();

  tick_interval_meter #(.M(M), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise tick_in for one cycle; on return the edge has been sampled.
  task automatic rise_edge();
    bus.tick_in = 1'b1;
    tick();
    bus.tick_in = 1'b0;
  endtask

  // Called right after rise_edge so the next rise lands g cycles after the last one.
  task automatic gap(input int g);
    repeat (g - 1) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic begin_meas(input logic cont);
    bus.continuous = cont;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.continuous = ~cont;
  endtask

  initial begin
    reset          = 1'b0;
    bus.tick_in    = 1'b0;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.stop       = 1'b0;
    repeat (2) tick();
    chk("rst_interval", 32'(bus.interval), 0);
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    reset = 1'b1;
    tick();

    // single-shot, pulses every 5 cycles
    begin_meas(1'b0);
    chk("ss_busy_arm", 32'(bus.busy), 1);
    rise_edge();
    chk("ss_open_valid", 32'(bus.valid), 0);
    gap(5);
    rise_edge();
    chk("ss_valid", 32'(bus.valid), 1);
    chk("ss_interval", 32'(bus.interval), 5);
    chk("ss_overflow", 32'(bus.overflow), 0);
    chk("ss_busy_done", 32'(bus.busy), 0);
    tick();
    chk("ss_valid_pulse", 32'(bus.valid), 0);
    repeat (3) tick();
    rise_edge();
    chk("ss_late_valid", 32'(bus.valid), 0);
    chk("ss_late_busy", 32'(bus.busy), 0);

    // continuous, spacings 3, 7, 4
    begin_meas(1'b1);
    rise_edge();
    gap(3);
    rise_edge();
    chk("c1_valid", 32'(bus.valid), 1);
    chk("c1_interval", 32'(bus.interval), 3);
    chk("c1_busy", 32'(bus.busy), 1);
    gap(7);
    rise_edge();
    chk("c2_valid", 32'(bus.valid), 1);
    chk("c2_interval", 32'(bus.interval), 7);
    gap(4);
    rise_edge();
    chk("c3_valid", 32'(bus.valid), 1);
    chk("c3_interval", 32'(bus.interval), 4);
    chk("c3_busy", 32'(bus.busy), 1);
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("c_stop_busy", 32'(bus.busy), 0);
    chk("c_stop_interval", 32'(bus.interval), 4);
    chk("c_stop_valid", 32'(bus.valid), 0);

    // single-shot timeout
    begin_meas(1'b0);
    rise_edge();
    repeat (19) tick();
    chk("to_early_valid", 32'(bus.valid), 0);
    chk("to_early_busy", 32'(bus.busy), 1);
    tick();
    chk("to_valid", 32'(bus.valid), 1);
    chk("to_interval", 32'(bus.interval), 20);
    chk("to_overflow", 32'(bus.overflow), 1);
    chk("to_busy", 32'(bus.busy), 0);

    // rise exactly at the ceiling
    begin_meas(1'b0);
    rise_edge();
    gap(20);
    rise_edge();
    chk("edge_m_valid", 32'(bus.valid), 1);
    chk("edge_m_interval", 32'(bus.interval), 20);
    chk("edge_m_overflow", 32'(bus.overflow), 0);

    // continuous timeout then re-arm
    begin_meas(1'b1);
    rise_edge();
    repeat (20) tick();
    chk("cto_valid", 32'(bus.valid), 1);
    chk("cto_overflow", 32'(bus.overflow), 1);
    chk("cto_interval", 32'(bus.interval), 20);
    chk("cto_busy", 32'(bus.busy), 1);
    repeat (3) tick();
    chk("cto_arm_busy", 32'(bus.busy), 1);
    rise_edge();
    chk("cto_open_valid", 32'(bus.valid), 0);
    gap(6);
    rise_edge();
    chk("cto_valid2", 32'(bus.valid), 1);
    chk("cto_interval2", 32'(bus.interval), 6);
    chk("cto_overflow2", 32'(bus.overflow), 0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // level input: high 10, low 2, high again
    begin_meas(1'b0);
    bus.tick_in = 1'b1;
    tick();
    repeat (9) tick();
    bus.tick_in = 1'b0;
    repeat (2) tick();
    chk("lvl_no_valid", 32'(bus.valid), 0);
    chk("lvl_busy", 32'(bus.busy), 1);
    bus.tick_in = 1'b1;
    tick();
    chk("lvl_valid", 32'(bus.valid), 1);
    chk("lvl_interval", 32'(bus.interval), 12);
    repeat (3) tick();
    bus.tick_in = 1'b0;
    tick();

    // stop mid-measure
    begin_meas(1'b0);
    rise_edge();
    repeat (3) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_valid", 32'(bus.valid), 0);
    chk("abort_interval", 32'(bus.interval), 12);
    chk("abort_overflow", 32'(bus.overflow), 0);

    // start and stop together
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("ss_collide_busy", 32'(bus.busy), 0);

    // rise coincident with start is ignored
    bus.continuous = 1'b0;
    bus.tick_in    = 1'b1;
    bus.start      = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.tick_in = 1'b0;
    tick();
    chk("coin_busy", 32'(bus.busy), 1);
    rise_edge();
    chk("coin_open_valid", 32'(bus.valid), 0);
    gap(4);
    rise_edge();
    chk("coin_valid", 32'(bus.valid), 1);
    chk("coin_interval", 32'(bus.interval), 4);

    // asynchronous reset mid-measure
    begin_meas(1'b1);
    rise_edge();
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_interval", 32'(bus.interval), 0);
    chk("arst_valid", 32'(bus.valid), 0);
    chk("arst_overflow", 32'(bus.overflow), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    bus.tick_in = 1'b1;
    tick();
    reset = 1'b1;
    begin_meas(1'b0);
    repeat (2) tick();
    chk("arst_hi_busy", 32'(bus.busy), 1);
    chk("arst_hi_valid", 32'(bus.valid), 0);
    bus.tick_in = 1'b0;
    tick();
    rise_edge();
    gap(3);
    rise_edge();
    chk("arst_valid2", 32'(bus.valid), 1);
    chk("arst_interval2", 32'(bus.interval), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
